// File: rtl/cube_root_check.sv
// cube_root_check
//   Checks a cube-root result produced upstream. It takes a triple (D, rez, r)
//   and verifies that rez^3 + r == D, that a nonzero remainder has the same
//   sign as D, and that |r| <= 3*rez^2 + 3*|rez|. rez^3 is built with two
//   11-step shift-add multiplies, so a verdict takes 23 edges after capture.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   triple handshake (in_ready only while idle)
//   D, rez, r           radicand, cube root, remainder (signed)
//   out_valid/out_ready verdict handshake, verdict held until accepted
//   pass, err_*         overall verdict and individual check failures
//   cube                computed rez^3
//   pass_cnt, fail_cnt  saturating verdict counters
//
// state | meaning
// ------+-------------------------------------------------
// IDLE  | waiting for a triple, in_ready=1
// MUL1  | sq = |rez|*|rez|, one shift-add step per edge
// MUL2  | mag = sq*|rez|, one shift-add step per edge
// CHECK | form cube, evaluate checks, update a counter
// DONE  | verdict presented until out_ready

module cube_root_check (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] D,
  input  logic signed [10:0] rez,
  input  logic signed [32:0] r,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               pass,
  output logic               err_sum,
  output logic               err_sign,
  output logic               err_range,
  output logic signed [31:0] cube,
  output logic        [15:0] pass_cnt,
  output logic        [15:0] fail_cnt
);

  typedef enum logic [2:0] {IDLE, MUL1, MUL2, CHECK, DONE} state_t;

  state_t             state;
  logic signed [31:0] d_q;
  logic signed [32:0] r_q;
  logic               neg_q;
  logic        [11:0] abs_q;
  logic        [20:0] sq_q;
  logic        [10:0] mplier;
  logic        [30:0] mcand;
  logic        [30:0] acc;
  logic         [3:0] step_cnt;

  logic        [11:0] rez_ext;
  logic        [11:0] rez_abs;
  logic        [30:0] acc_next;
  logic               step_last;

  logic        [31:0] mag32;
  logic        [31:0] cube_c;
  logic signed [44:0] cube45;
  logic signed [44:0] d45;
  logic signed [44:0] r45;
  logic signed [44:0] sum45;
  logic signed [44:0] r_abs45;
  logic signed [44:0] sq45;
  logic signed [44:0] abs45;
  logic signed [44:0] bound45;
  logic               err_sum_c;
  logic               err_sign_c;
  logic               err_range_c;
  logic               pass_c;

  assign in_ready = (state == IDLE);

  // Two's-complement magnitude in 12 bits so rez=-1024 yields 1024.
  assign rez_ext = {rez[10], rez};
  assign rez_abs = rez[10] ? (~rez_ext + 12'd1) : rez_ext;

  assign acc_next  = acc + (mplier[0] ? mcand : 31'd0);
  assign step_last = (step_cnt == 4'd0);

  // mag <= 2^30, so negating inside 32 bits never overflows.
  assign mag32  = {1'b0, acc};
  assign cube_c = neg_q ? (~mag32 + 32'd1) : mag32;

  always_comb begin
    cube45  = {{13{cube_c[31]}}, cube_c};
    d45     = {{13{d_q[31]}}, d_q};
    r45     = {{12{r_q[32]}}, r_q};
    sum45   = cube45 + r45;
    r_abs45 = r_q[32] ? -r45 : r45;
    sq45    = {24'd0, sq_q};
    abs45   = {33'd0, abs_q};
    bound45 = (sq45 <<< 1) + sq45 + (abs45 <<< 1) + abs45;

    err_sum_c   = (sum45 != d45);
    err_sign_c  = (r_q != 33'sd0) && (r_q[32] != d_q[31]);
    err_range_c = (r_abs45 > bound45);
    pass_c      = ~(err_sum_c | err_sign_c | err_range_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      d_q       <= '0;
      r_q       <= '0;
      neg_q     <= 1'b0;
      abs_q     <= '0;
      sq_q      <= '0;
      mplier    <= '0;
      mcand     <= '0;
      acc       <= '0;
      step_cnt  <= '0;
      out_valid <= 1'b0;
      pass      <= 1'b0;
      err_sum   <= 1'b0;
      err_sign  <= 1'b0;
      err_range <= 1'b0;
      cube      <= '0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            d_q      <= D;
            r_q      <= r;
            neg_q    <= rez[10];
            abs_q    <= rez_abs;
            mplier   <= rez_abs[10:0];
            mcand    <= {19'd0, rez_abs};
            acc      <= '0;
            step_cnt <= 4'd10;
            state    <= MUL1;
          end
        end

        MUL1: begin
          if (step_last) begin
            // Square is complete; it becomes the multiplicand for the cube.
            sq_q     <= acc_next[20:0];
            mcand    <= acc_next;
            acc      <= '0;
            mplier   <= abs_q[10:0];
            step_cnt <= 4'd10;
            state    <= MUL2;
          end else begin
            acc      <= acc_next;
            mcand    <= mcand << 1;
            mplier   <= mplier >> 1;
            step_cnt <= step_cnt - 4'd1;
          end
        end

        MUL2: begin
          acc      <= acc_next;
          mcand    <= mcand << 1;
          mplier   <= mplier >> 1;
          step_cnt <= step_cnt - 4'd1;
          if (step_last) state <= CHECK;
        end

        CHECK: begin
          cube      <= cube_c;
          err_sum   <= err_sum_c;
          err_sign  <= err_sign_c;
          err_range <= err_range_c;
          pass      <= pass_c;
          if (pass_c) begin
            if (pass_cnt != 16'hFFFF) pass_cnt <= pass_cnt + 16'd1;
          end else begin
            if (fail_cnt != 16'hFFFF) fail_cnt <= fail_cnt + 16'd1;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cube_root_check.sv
module tb_cube_root_check;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] D = '0;
  logic signed [10:0] rez = '0;
  logic signed [32:0] r = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic               pass, err_sum, err_sign, err_range;
  logic signed [31:0] cube;
  logic        [15:0] pass_cnt, fail_cnt;

  int checks = 0;
  int failures = 0;
  int exp_pc = 0;
  int exp_fc = 0;

  cube_root_check dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .D(D), .rez(rez), .r(r), .out_valid(out_valid), .out_ready(out_ready),
    .pass(pass), .err_sum(err_sum), .err_sign(err_sign), .err_range(err_range),
    .cube(cube), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [31:0] d;
    logic signed [10:0] rz;
    logic signed [32:0] rr;
    logic signed [31:0] cube;
    logic               pass;
    logic               es;
    logic               eg;
    logic               er;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Present one triple, then scramble the inputs while busy; returns the
  // number of edges from capture to out_valid (0 on timeout).
  task automatic issue(input logic signed [31:0] d, input logic signed [10:0] rz,
                       input logic signed [32:0] rr, output int lat);
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; D = d; rez = rz; r = rr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    D = $signed($urandom); rez = 11'($urandom); r = {1'b0, $urandom};
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=no_out_valid expected=out_valid");
    end
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("out_valid_drop", out_valid, 0);
    chk("in_ready_back", in_ready, 1);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic check_verdict(input vec_t v);
    chk("cube", cube, v.cube);
    chk("pass", pass, v.pass);
    chk("err_sum", err_sum, v.es);
    chk("err_sign", err_sign, v.eg);
    chk("err_range", err_range, v.er);
  endtask

  int lat;

  initial begin
    vecs[0]  = '{-32'sd1000000, -11'sd100, 33'sd0,    -32'sd1000000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'sd75366,    11'sd42,   33'sd1278, 32'sd74088,    1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{32'sd1730482,  11'sd120,  33'sd2482, 32'sd1728000,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'sd421,      11'sd8,    -33'sd91,  32'sd512,      1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{32'sd421,      11'sd6,    33'sd205,  32'sd216,      1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{32'sd0,        -11'sd1024, 33'sd0,   -32'sd1073741824, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'sd0,        11'sd0,    33'sd0,    32'sd0,        1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{32'sd7,        11'sd0,    33'sd3,    32'sd0,        1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{32'sd1070599267, 11'sd1023, 33'sd100, 32'sd1070599167, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{-32'sd3,       -11'sd1,   -33'sd2,   -32'sd1,       1'b1, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{-32'sd5,       -11'sd2,   33'sd3,    -32'sd8,       1'b0, 1'b0, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cube", cube, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    chk("rst_fail_cnt", fail_cnt, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      issue(vecs[i].d, vecs[i].rz, vecs[i].rr, lat);
      chk("latency", lat, 23);
      check_verdict(vecs[i]);
      if (vecs[i].pass) exp_pc++; else exp_fc++;
      chk("pass_cnt", pass_cnt, exp_pc);
      chk("fail_cnt", fail_cnt, exp_fc);
      accept();
    end

    // Stall in DONE with in_valid and changing data
    issue(vecs[1].d, vecs[1].rz, vecs[1].rr, lat);
    chk("stall_latency", lat, 23);
    exp_pc++;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      D = $signed($urandom); rez = 11'($urandom); r = {1'b0, $urandom};
      @(posedge clk);
      #1;
      chk("stall_out_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      check_verdict(vecs[1]);
      chk("stall_pass_cnt", pass_cnt, exp_pc);
      chk("stall_fail_cnt", fail_cnt, exp_fc);
    end
    @(negedge clk);
    in_valid = 1'b0;
    accept();
    chk("after_stall_pass_cnt", pass_cnt, exp_pc);

    // Reset during MUL2 step 5
    @(negedge clk);
    in_valid = 1'b1; D = vecs[0].d; rez = vecs[0].rz; r = vecs[0].rr;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (16) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_pass_cnt", pass_cnt, 0);
    chk("midrst_fail_cnt", fail_cnt, 0);
    chk("midrst_cube", cube, 0);
    exp_pc = 0;
    exp_fc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("midrst_no_valid", out_valid, 0);
    chk("midrst_cnt_hold", pass_cnt + fail_cnt, 0);

    issue(vecs[3].d, vecs[3].rz, vecs[3].rr, lat);
    chk("post_rst_latency", lat, 23);
    check_verdict(vecs[3]);
    chk("post_rst_fail_cnt", fail_cnt, 1);
    chk("post_rst_pass_cnt", pass_cnt, 0);
    accept();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
